// File: rtl/quick_uart_pkg.sv
// -----------------------------------------------------------------------------
// quick_uart_pkg
// Shared types and helpers for the quick_uart transmit-side arbiter.
//   arb_state_e : arbiter FSM states (IDLE arbitrates, LOCKED forwards bytes).
//   arb_dbg_t   : debug snapshot of the arbiter FSM (state, rr_ptr, burst_cnt),
//                 fixed-width so it is independent of the block parameters.
//   clog2_min1  : $clog2 that never returns 0, so a 1-requester build still
//                 gets a 1-bit grant index.
// -----------------------------------------------------------------------------
package quick_uart_pkg;

  // Debug field widths cover the full legal parameter range (NUM_REQ <= 16).
  localparam int unsigned DBG_PTR_W = 4;
  localparam int unsigned DBG_CNT_W = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_state_e             state;
    logic [DBG_PTR_W-1:0]   rr_ptr;
    logic [DBG_CNT_W-1:0]   burst_cnt;
  } arb_dbg_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quick_uart_rr_pick.sv
// -----------------------------------------------------------------------------
// quick_uart_rr_pick
// Combinational round-robin priority scan. Starting at ptr_i and moving upward
// (modulo NUM_REQ) it returns the first set bit of req_i.
// Ports:
//   req_i   [NUM_REQ] request vector
//   ptr_i   [IW]      index with the highest priority (must be < NUM_REQ)
//   found_o           at least one request is set
//   idx_o   [IW]      index of the first set request in scan order
// -----------------------------------------------------------------------------
module quick_uart_rr_pick
  import quick_uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  // One extra bit so ptr + offset (at most 2*NUM_REQ-2) never overflows
  // before the modulo fold.
  logic [IW:0] pos;

  // Scanning from the farthest offset down to offset 0 lets the closest
  // requester (smallest offset from ptr_i) overwrite any farther match.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos = {1'b0, ptr_i} + (IW+1)'(off);
      if (pos >= (IW+1)'(NUM_REQ)) begin
        pos = pos - (IW+1)'(NUM_REQ);
      end
      if (req_i[pos[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/quick_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// quick_uart_tx_arbiter
// Round-robin arbiter sharing one quick_uart_tx between NUM_REQ byte-stream
// requesters. A grant is held for a whole message: it ends on the handshake
// carrying req_last_i, or after MAX_BURST bytes (MAX_BURST = 0: no cap).
// Arbitration takes one IDLE cycle; while LOCKED the granted channel is passed
// straight through to the UART.
//
// Handshake semantics (all channels): a byte moves on a cycle where valid and
// ready are both high at the rising clock edge. A source must hold valid and
// data stable until that happens; ready may change freely. The arbiter never
// drops tx_valid_o on its own while LOCKED, only when the granted source does.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i [N]      per-requester byte valid
//   req_data_i  [N*DB]   requester k at bits [k*DATA_BITS +: DATA_BITS]
//   req_last_i  [N]      final byte of a requester's message
//   req_ready_o [N]      per-requester ready (only the granted bit can be 1)
//   tx_valid_o, tx_data_o, tx_ready_i   byte port toward quick_uart_tx
//   grant_o              current / most recent granted requester
//   busy_o               high while LOCKED
//   dbg_o                FSM state, rr_ptr and burst counter snapshot
// -----------------------------------------------------------------------------
module quick_uart_tx_arbiter
  import quick_uart_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_BITS = 8,
  parameter  int MAX_BURST = 16,
  localparam int GW        = clog2_min1(NUM_REQ),
  localparam int CW        = clog2_min1(MAX_BURST + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           tx_valid_o,
  output logic [DATA_BITS-1:0]           tx_data_o,
  input  logic                           tx_ready_i,
  output logic [GW-1:0]                  grant_o,
  output logic                           busy_o,
  output arb_dbg_t                       dbg_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e    state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_ptr_q;
  logic [GW-1:0] rr_ptr_d;
  logic [CW-1:0] burst_cnt_q;
  logic          busy_q;

  logic          pick_found;
  logic [GW-1:0] pick_idx;

  logic          hs;
  logic          cap_hit;
  logic          burst_end;

  // ---------------------------------------------------------------------------
  // Round-robin scan over the raw valid vector
  // ---------------------------------------------------------------------------
  quick_uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Pass-through. Gated by the registered state, so an asynchronous reset
  // drops the lock and all of these outputs without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (state_q == ARB_LOCKED) begin
      tx_valid_o           = req_valid_i[grant_q];
      tx_data_o            = req_data_i[grant_q*DATA_BITS +: DATA_BITS];
      req_ready_o[grant_q] = tx_ready_i;
    end
  end

  assign hs = tx_valid_o && tx_ready_i;

  // The cap compares the count including the byte moving this cycle.
  always_comb begin
    cap_hit = 1'b0;
    if (MAX_BURST != 0) begin
      cap_hit = (({1'b0, burst_cnt_q} + 1'b1) == (CW+1)'(MAX_BURST));
    end
  end

  // last and cap on the same handshake are a single burst end.
  assign burst_end = hs && (req_last_i[grant_q] || cap_hit);

  // The requester just served drops to lowest priority; wrap explicitly so
  // non-power-of-two NUM_REQ folds back to 0.
  assign rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_q     <= pick_idx;
            burst_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          // No timeout: an idle granted channel keeps the lock.
          if (burst_end) begin
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= ARB_IDLE;
          end else if (hs) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;

  always_comb begin
    dbg_o           = '0;
    dbg_o.state     = state_q;
    dbg_o.rr_ptr    = DBG_PTR_W'(rr_ptr_q);
    dbg_o.burst_cnt = DBG_CNT_W'(burst_cnt_q);
  end

endmodule
